// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: reset/bubble defaults, instruction field positions,
// opcode constants and the instruction-fetch FSM state type.
// No logic; compile-time constants only.
package mips32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } if_state_e;

  // Instruction addresses are word aligned; low two bits of any target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pipeline_ifid_reg.sv
// IF/ID pipeline register holding instruction word, PC+4 and valid flag.
// Latency: 1 cycle from load to outputs.
// Backpressure: i_en=0 holds all contents; i_flush / no-load insert a bubble.
module ifid_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_en,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_ir,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc4,
  output logic        o_vld
);

  logic [31:0] r_ir;
  logic [31:0] r_pc4;
  logic        r_vld;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ir  <= NOP_INST;
      r_pc4 <= 32'h0000_0000;
      r_vld <= 1'b0;
    end else if (i_en) begin
      if (i_flush) begin
        r_ir  <= NOP_INST;
        r_pc4 <= 32'h0000_0000;
        r_vld <= 1'b0;
      end else if (i_load) begin
        r_ir  <= i_ir;
        r_pc4 <= i_pc4;
        r_vld <= 1'b1;
      end else begin
        // Fetch bubble: pc4 is left as-is, only the word and valid change.
        r_ir  <= NOP_INST;
        r_vld <= 1'b0;
      end
    end
  end

  assign o_ir  = r_ir;
  assign o_pc4 = r_pc4;
  assign o_vld = r_vld;

endmodule

// File: rtl/if_stage_pipeline.sv
// MIPS32 instruction-fetch stage with IF/ID register; optional DELAY_SLOT_EN keeps the word after a redirect.
// Latency: word accepted at edge N is on ir after edge N. Backpressure: imem_ready=0 holds PC and
// loads bubbles; writepc/writeir=0 stall PC / IF/ID.
module if_stage_pipeline
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips32_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = mips32_pkg::NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        writepc,
  input  logic        writeir,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ir,
  output logic [31:0] pc4_id,
  output logic        valid_id,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [5:0]  func
);

  if_state_e   r_state;
  if_state_e   w_state_nxt;
  logic        w_fetch;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc4;
  logic        w_accept;
  logic        w_flush;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    case (r_state)
      IDLE:    w_state_nxt = FETCH;
      FETCH:   w_fetch     = 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pc4    = r_pc + 32'd4;
  assign w_accept = w_fetch & imem_ready;

  // A redirect while imem_ready=0 simply moves the address; the pending word is never latched.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_fetch && writepc) begin
      if (jump)            w_pc_nxt = word_align(jpc);
      else if (branch)     w_pc_nxt = word_align(bpc);
      else if (imem_ready) w_pc_nxt = w_pc4;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_pc <= word_align(RESET_PC);
    else       r_pc <= w_pc_nxt;
  end

`ifdef DELAY_SLOT_EN
  assign w_flush = 1'b0;
`else
  assign w_flush = w_fetch & writepc & (jump | branch);
`endif

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid (
    .clk     (clk),
    .clrn    (clrn),
    .i_en    (writeir),
    .i_flush (w_flush),
    .i_load  (w_accept),
    .i_ir    (imem_rdata),
    .i_pc4   (w_pc4),
    .o_ir    (ir),
    .o_pc4   (pc4_id),
    .o_vld   (valid_id)
  );

  assign imem_req  = w_fetch;
  assign imem_addr = r_pc;

  assign op   = ir[OP_HI:OP_LO];
  assign rs   = ir[RS_HI:RS_LO];
  assign rt   = ir[RT_HI:RT_LO];
  assign func = ir[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_if_stage_pipeline.sv
// Directed table-driven bench for if_stage_pipeline, plus hand-written reset sequences.
module tb_if_stage_pipeline;
  import mips32_pkg::*;

  logic        clk;
  logic        clrn;
  logic        writepc, writeir, branch, jump, imem_ready;
  logic [31:0] bpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, ir, pc4_id;
  logic        valid_id;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt;

  int total = 0;
  int bad   = 0;

  if_stage_pipeline dut (
    .clk        (clk),
    .clrn       (clrn),
    .writepc    (writepc),
    .writeir    (writeir),
    .branch     (branch),
    .jump       (jump),
    .bpc        (bpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .ir         (ir),
    .pc4_id     (pc4_id),
    .valid_id   (valid_id),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .func       (func)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a few real encodings at fixed addresses, otherwise a tagged address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_001C: return {OP_LW,  5'd1, 5'd2, 16'h0000};
      32'h0000_0028: return {OP_SW,  5'd2, 5'd3, 16'h0004};
      32'h0000_002C: return {OP_BEQ, 5'd1, 5'd2, 16'h0003};
      32'h0000_0034: return {OP_J,   26'h000_0040};
      default:       return 32'hE000_0000 | a;
    endcase
  endfunction

  assign imem_rdata = memword(imem_addr);

  typedef struct {
    logic        wpc, wir, br, jp, rdy;
    logic [31:0] bpc, jpc;
    logic [31:0] e_addr, e_ir, e_pc4;
    logic        e_vld;
  } vec_t;

  function automatic vec_t mk(input logic wpc, input logic wir, input logic br, input logic jp,
                              input logic rdy, input logic [31:0] b, input logic [31:0] j,
                              input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep, input logic ev);
    vec_t v;
    v.wpc = wpc; v.wir = wir; v.br = br; v.jp = jp; v.rdy = rdy;
    v.bpc = b; v.jpc = j; v.e_addr = ea; v.e_ir = ei; v.e_pc4 = ep; v.e_vld = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  vec_t tv[32];

  initial begin
    // wpc wir br jp rdy bpc jpc | addr ir pc4 vld
    tv[0]  = mk(1,1,0,0,1, 0,0, 32'h04, 32'hE000_0000, 32'h04, 1);
    tv[1]  = mk(1,1,0,0,1, 0,0, 32'h08, 32'hE000_0004, 32'h08, 1);
    tv[2]  = mk(1,1,0,0,1, 0,0, 32'h0C, 32'hE000_0008, 32'h0C, 1);
    tv[3]  = mk(1,1,0,0,1, 0,0, 32'h10, 32'hE000_000C, 32'h10, 1);
    tv[4]  = mk(1,1,0,0,0, 0,0, 32'h10, 32'h0000_0000, 32'h10, 0);
    tv[5]  = mk(1,1,0,0,0, 0,0, 32'h10, 32'h0000_0000, 32'h10, 0);
    tv[6]  = mk(1,1,0,0,0, 0,0, 32'h10, 32'h0000_0000, 32'h10, 0);
    tv[7]  = mk(1,1,0,0,1, 0,0, 32'h14, 32'hE000_0010, 32'h14, 1);
    tv[8]  = mk(1,1,0,0,1, 0,0, 32'h18, 32'hE000_0014, 32'h18, 1);
    tv[9]  = mk(1,1,0,0,1, 0,0, 32'h1C, 32'hE000_0018, 32'h1C, 1);
    tv[10] = mk(1,1,0,0,1, 0,0, 32'h20, 32'h8C22_0000, 32'h20, 1);
    tv[11] = mk(0,0,0,0,1, 0,0, 32'h20, 32'h8C22_0000, 32'h20, 1);
    tv[12] = mk(1,1,0,0,1, 0,0, 32'h24, 32'hE000_0020, 32'h24, 1);
    tv[13] = mk(1,1,0,0,1, 0,0, 32'h28, 32'hE000_0024, 32'h28, 1);
    tv[14] = mk(1,1,0,0,1, 0,0, 32'h2C, 32'hAC43_0004, 32'h2C, 1);
    tv[15] = mk(1,1,0,0,1, 0,0, 32'h30, 32'h1022_0003, 32'h30, 1);
    tv[16] = mk(1,1,0,0,1, 0,0, 32'h34, 32'hE000_0030, 32'h34, 1);
    tv[17] = mk(1,1,0,0,1, 0,0, 32'h38, 32'h0800_0040, 32'h38, 1);
    tv[18] = mk(1,1,0,0,1, 0,0, 32'h3C, 32'hE000_0038, 32'h3C, 1);
    tv[19] = mk(1,1,0,0,1, 0,0, 32'h40, 32'hE000_003C, 32'h40, 1);
`ifdef DELAY_SLOT_EN
    tv[20] = mk(1,1,1,0,1, 32'h100,0, 32'h100, 32'hE000_0040, 32'h44, 1);
`else
    tv[20] = mk(1,1,1,0,1, 32'h100,0, 32'h100, 32'h0000_0000, 32'h00, 0);
`endif
    tv[21] = mk(1,1,0,0,1, 0,0, 32'h104, 32'hE000_0100, 32'h104, 1);
`ifdef DELAY_SLOT_EN
    tv[22] = mk(1,1,1,1,1, 32'h300,32'h203, 32'h200, 32'hE000_0104, 32'h108, 1);
`else
    tv[22] = mk(1,1,1,1,1, 32'h300,32'h203, 32'h200, 32'h0000_0000, 32'h000, 0);
`endif
    tv[23] = mk(1,1,0,0,1, 0,0, 32'h204, 32'hE000_0200, 32'h204, 1);
`ifdef DELAY_SLOT_EN
    tv[24] = mk(1,1,0,1,0, 0,32'hFFFF_FFF1, 32'hFFFF_FFF0, 32'h0000_0000, 32'h204, 0);
`else
    tv[24] = mk(1,1,0,1,0, 0,32'hFFFF_FFF1, 32'hFFFF_FFF0, 32'h0000_0000, 32'h000, 0);
`endif
    tv[25] = mk(1,1,0,0,1, 0,0, 32'hFFFF_FFF4, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 1);
    tv[26] = mk(1,1,0,0,1, 0,0, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 1);
    tv[27] = mk(1,1,0,0,1, 0,0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1);
    tv[28] = mk(1,1,0,0,1, 0,0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1);
    tv[29] = mk(1,0,0,0,1, 0,0, 32'h04, 32'hFFFF_FFFC, 32'h00, 1);
    tv[30] = mk(0,1,1,0,1, 32'h80,0, 32'h04, 32'hE000_0004, 32'h08, 1);
    tv[31] = mk(1,1,0,0,1, 0,0, 32'h08, 32'hE000_0004, 32'h08, 1);

    writepc = 1'b1; writeir = 1'b1; branch = 1'b0; jump = 1'b0;
    bpc = '0; jpc = '0; imem_ready = 1'b1;
    clrn = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_ir",    ir, 32'h0);
    chk("rst_pc4",   pc4_id, 32'h0);
    chk("rst_vld",   {31'b0, valid_id}, 32'h0);
    clrn = 1'b1;
    #1;
    chk("idle_req",  {31'b0, imem_req}, 32'h0);
    @(posedge clk); #1;
    chk("e1_req",    {31'b0, imem_req}, 32'h1);
    chk("e1_addr",   imem_addr, 32'h0);
    chk("e1_vld",    {31'b0, valid_id}, 32'h0);
    chk("e1_ir",     ir, 32'h0);

    for (int i = 0; i < 32; i++) begin
      writepc = tv[i].wpc; writeir = tv[i].wir; branch = tv[i].br; jump = tv[i].jp;
      imem_ready = tv[i].rdy; bpc = tv[i].bpc; jpc = tv[i].jpc;
      @(posedge clk); #1;
      chk($sformatf("v%0d_req", i),  {31'b0, imem_req}, 32'h1);
      chk($sformatf("v%0d_addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("v%0d_ir", i),   ir, tv[i].e_ir);
      chk($sformatf("v%0d_pc4", i),  pc4_id, tv[i].e_pc4);
      chk($sformatf("v%0d_vld", i),  {31'b0, valid_id}, {31'b0, tv[i].e_vld});
      chk($sformatf("v%0d_fields", i), {op, rs, rt, 10'b0, func},
          {tv[i].e_ir[31:26], tv[i].e_ir[25:21], tv[i].e_ir[20:16], 10'b0, tv[i].e_ir[5:0]});
      if (!tv[i].e_vld) chk($sformatf("v%0d_bubble_op", i), {26'b0, op}, {26'b0, OP_RTYPE});
      if (i == 10)      chk("lw_op", {26'b0, op}, {26'b0, OP_LW});
    end

    // Asynchronous reset asserted mid-cycle, then a full restart.
    writepc = 1'b1; writeir = 1'b1; branch = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    #2;
    clrn = 1'b0;
    #1;
    chk("arst_req",  {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_ir",   ir, 32'h0);
    chk("arst_pc4",  pc4_id, 32'h0);
    chk("arst_vld",  {31'b0, valid_id}, 32'h0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    chk("rel_idle_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk); #1;
    chk("rel_e1_req",  {31'b0, imem_req}, 32'h1);
    chk("rel_e1_addr", imem_addr, 32'h0);
    chk("rel_e1_vld",  {31'b0, valid_id}, 32'h0);
    @(posedge clk); #1;
    chk("rel_e2_addr", imem_addr, 32'h4);
    chk("rel_e2_ir",   ir, 32'hE000_0000);
    chk("rel_e2_vld",  {31'b0, valid_id}, 32'h1);
    @(posedge clk); #1;
    chk("rel_e3_addr", imem_addr, 32'h8);
    chk("rel_e3_ir",   ir, 32'hE000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage_pipeline.md
Name: if_stage_pipeline

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS32 pipeline. It holds the PC and fetches from instruction memory with a ready handshake. It selects the next PC from PC+4, branch target or jump target, and presents the fetched word and its decoded fields to the ID-stage control unit. It obeys the control unit's writepc/writeir stall controls and its branch/jump redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_INST, 32'h0000_0000, bubble word (sll $0,$0,0) inserted into IF/ID.

Ports:
clk  in  1  pipeline clock, rising edge.
clrn  in  1  reset, asynchronous, active-low.
writepc  in  1  from control unit; 0 = hold PC (load-use stall).
writeir  in  1  from control unit; 0 = hold IF/ID register.
branch  in  1  taken beq resolved in ID.
jump  in  1  j resolved in ID.
bpc  in  32  branch target.
jpc  in  32  jump target.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address (= PC).
imem_rdata  in  32  instruction word, valid when imem_ready=1.
imem_ready  in  1  fetch completes this cycle.
ir  out  32  IF/ID instruction.
pc4_id  out  32  IF/ID PC+4.
valid_id  out  1  IF/ID holds a real instruction.
op  out  6  ir[31:26].
rs  out  5  ir[25:21].
rt  out  5  ir[20:16].
func  out  6  ir[5:0].

Behaviour:
- Reset (clrn=0, async): pc=RESET_PC, ir=NOP_INST, pc4_id=0, valid_id=0, imem_req=0, FSM=IDLE.
- FSM IDLE: one cycle after reset release, imem_req=0, PC held. Then unconditionally -> FETCH.
- FSM FETCH: imem_req=1 and imem_addr=pc every cycle. No exit other than reset.
- pc4 = pc + 32'd4, with wrap-around mod 2^32.
- PC update at a clock edge in FETCH. Priority order:
  - writepc=0: hold.
  - else jump=1: pc <= {jpc[31:2],2'b00}. Jump wins over branch when both are asserted.
  - else branch=1: pc <= {bpc[31:2],2'b00}.
  - else imem_ready=1: pc <= pc4.
  - else hold (fetch wait).
- A redirect while imem_ready=0 abandons the outstanding fetch. imem must accept an address change at any cycle; the discarded data is never latched.
- IF/ID update at a clock edge. Priority order:
  - writeir=0: hold ir, pc4_id, valid_id.
  - else redirect (jump|branch) with writepc=1: flush, i.e. ir<=NOP_INST, valid_id<=0, pc4_id<=0 (default build).
  - else imem_ready=1: ir<=imem_rdata, pc4_id<=pc4, valid_id<=1.
  - else bubble: ir<=NOP_INST, valid_id<=0.
- In IDLE, IF/ID loads a bubble if writeir=1.
- Latency: a word accepted at edge N appears on ir after edge N and drives the control unit during cycle N+1.
- The control unit must not assert branch/jump while writepc=0. If it does, the redirect is ignored; no assertion is required.
- op/rs/rt/func are pure slices of ir, with no extra register.

Optional Feature:
DELAY_SLOT_EN.
- Defined: MIPS branch-delay-slot semantics. A redirect does not flush IF/ID; the fetched word (or a bubble if imem_ready=0) is loaded as normal, so the instruction after a branch/jump executes.
- Undefined: flush as specified above, giving one bubble per taken branch/jump.

Decomposition:
- Shared package mips32_pkg:
  - RESET_PC default and NOP_INST constant.
  - Opcode/func field bit positions.
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J).
  - IF FSM state typedef (IDLE, FETCH).
- One natural sub-module: ifid_reg, the IF/ID register with enable (writeir) and flush, holding ir/pc4_id/valid_id.

Test Plan:
1. Reset sequence: clrn low async mid-cycle, then released, with imem_ready=1. Required: pc=0, ir=0, valid_id=0; one IDLE cycle with imem_req=0; then imem_addr steps 0,4,8 on consecutive cycles and ir follows the fetched words one cycle later.
2. Fetch wait: imem_ready=0 for 3 cycles at pc=0x10. Required: imem_addr holds 0x10; three bubbles with valid_id=0, ir=0; then on ready, ir=word@0x10 and pc4_id=0x14.
3. Load-use stall: writepc=0, writeir=0 for 1 cycle at pc=0x20, ir=0x8C220000. Required: pc stays 0x20, ir unchanged; the next cycle resumes at 0x24.
4. Taken branch: branch=1, bpc=0x100, at pc=0x40. Required: next pc=0x100; ir=0, valid_id=0 (DELAY_SLOT_EN off), or ir=word@0x40 (DELAY_SLOT_EN on).
5. Simultaneous jump and branch: jump=1, jpc=0x203, branch=1, bpc=0x300. Required: pc=0x200 (alignment bits cleared, jump wins).
6. Wrap-around: pc=0xFFFF_FFFC with ready. Required: next pc=0x0000_0000 and pc4_id=0x0000_0000.
